// File: rtl/tipi_rpi_shift_out_if.sv
// Bundles the RPi read-back pins with the TD/TC latch outputs.
//   rpi_sclk      RPi shift clock (asynchronous to the board clock)
//   rpi_regsel    RPi register select
//   rpi_sle       RPi load strobe; its rising edge starts a transfer
//   ti_td/ti_tc   TD/TC latch contents, bit 0 is the MSB
//   rpi_sdata_out serial data to the RPi, MSB first
//   busy          high while a snapshot is being shifted out
// master: the side driving the RPi strobes and latches; slave: the shifter.
interface tipi_rpi_shift_out_if;
   logic       rpi_sclk;
   logic [1:0] rpi_regsel;
   logic       rpi_sle;
   logic [0:7] ti_td;
   logic [0:7] ti_tc;
   logic       rpi_sdata_out;
   logic       busy;

   modport master (
      output rpi_sclk, rpi_regsel, rpi_sle, ti_td, ti_tc,
      input  rpi_sdata_out, busy
   );

   modport slave (
      input  rpi_sclk, rpi_regsel, rpi_sle, ti_td, ti_tc,
      output rpi_sdata_out, busy
   );
endinterface

// File: rtl/tipi_rpi_shift_out.sv
// RPi read-back of the TI-written TD/TC registers. On a rising rpi_sle the
// selected latch is snapshotted and shifted out MSB first, one bit per rising
// rpi_sclk. All RPi strobes are synchronized into clk; nothing runs on
// rpi_sclk itself.
// Ports:
//   clk    board clock (50MHz), rising edge
//   rst_n  asynchronous reset, active low
//   bus    tipi_rpi_shift_out_if.slave (strobes, latches, serial out, busy)
module tipi_rpi_shift_out #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [1:0] TD_SEL      = 2'b10,
   parameter logic [1:0] TC_SEL      = 2'b11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tipi_rpi_shift_out_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, SHIFT, DONE} state_t;

   state_t                        state, state_nx;
   logic [SYNC_STAGES-1:0]        sclk_sync, sle_sync;
   logic [SYNC_STAGES-1:0][1:0]   regsel_sync;
   logic                          sclk_d, sle_d;
   logic                          sclk_pulse, sle_pulse;
   logic                          sel_td, sel_tc, sel_ok;
   logic [0:7]                    src, src_q, src_qq;
   logic [0:7]                    shreg;
   logic [3:0]                    cnt;
   logic                          stable;

   // Synchronizers plus one history flop for edge detection on sclk/sle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync   <= '0;
         sle_sync    <= '0;
         regsel_sync <= '0;
         sclk_d      <= 1'b0;
         sle_d       <= 1'b0;
      end else begin
         sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], bus.rpi_sclk};
         sle_sync    <= {sle_sync[SYNC_STAGES-2:0], bus.rpi_sle};
         regsel_sync <= {regsel_sync[SYNC_STAGES-2:0], bus.rpi_regsel};
         sclk_d      <= sclk_sync[SYNC_STAGES-1];
         sle_d       <= sle_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_pulse = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
   assign sle_pulse  = sle_sync[SYNC_STAGES-1] & ~sle_d;
   assign sel_td     = (regsel_sync[SYNC_STAGES-1] == TD_SEL);
   assign sel_tc     = (regsel_sync[SYNC_STAGES-1] == TC_SEL);
   assign sel_ok     = sel_td | sel_tc;
   assign src        = sel_td ? bus.ti_td : bus.ti_tc;

   // Two-deep history of the selected latch; a snapshot is only taken once
   // two consecutive samples agree, so a TI write in flight is never split.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q  <= '0;
         src_qq <= '0;
      end else begin
         src_q  <= src;
         src_qq <= src_q;
      end
   end

   assign stable = (src_q == src_qq);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; in SHIFT a load strobe outranks a shift pulse.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (sle_pulse && sel_ok) state_nx = SETTLE;
         SETTLE:     if (stable) state_nx = SHIFT;
         SHIFT: begin
            if (sle_pulse)                       state_nx = SETTLE;
            else if (sclk_pulse && cnt == 4'd7)  state_nx = DONE;
         end
         default:    state_nx = IDLE;
      endcase
   end

   // Shift register and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (state == SETTLE && stable) begin
         shreg <= src_q;
         cnt   <= '0;
      end else if (state == SHIFT) begin
         if (sle_pulse) begin
            cnt <= '0;
         end else if (sclk_pulse) begin
            shreg <= {shreg[1:7], 1'b0};
            cnt   <= cnt + 4'd1;
         end
      end
   end

   // Outputs
   always_comb begin
      bus.rpi_sdata_out = 1'b0;
      bus.busy          = 1'b0;
      if (state == SHIFT) begin
         bus.rpi_sdata_out = shreg[0];
         bus.busy          = 1'b1;
      end
   end

endmodule

// File: tb/tb_tipi_rpi_shift_out.sv
module tb_tipi_rpi_shift_out;
   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   tipi_rpi_shift_out_if bus ();

   tipi_rpi_shift_out #(.SYNC_STAGES(SYNC), .TD_SEL(2'b10), .TC_SEL(2'b11)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [1:0] regsel;
      logic [7:0] td;
      logic [7:0] tc;
      logic       valid;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic pulse_sle();
      @(posedge clk); #1 bus.rpi_sle = 1'b1;
      repeat (10) @(posedge clk);
      #1 bus.rpi_sle = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic pulse_sclk();
      @(posedge clk); #1 bus.rpi_sclk = 1'b1;
      repeat (10) @(posedge clk);
      #1 bus.rpi_sclk = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   // Checks n bits of exp (MSB first, starting at bit index first), one sclk each.
   task automatic shift_check(input string nm, input logic [7:0] exp,
                              input int n, input int first, input logic valid);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({nm, "_bit"}, bus.rpi_sdata_out, valid ? exp[7-first-i] : 1'b0);
         check({nm, "_busy"}, bus.busy, valid);
         pulse_sclk();
      end
   endtask

   task automatic check_idle(input string nm);
      @(negedge clk);
      check({nm, "_end_busy"}, bus.busy, 1'b0);
      check({nm, "_end_sdata"}, bus.rpi_sdata_out, 1'b0);
   endtask

   initial begin
      bus.rpi_sclk   = 1'b0;
      bus.rpi_sle    = 1'b0;
      bus.rpi_regsel = 2'b00;
      bus.ti_td      = 8'h00;
      bus.ti_tc      = 8'h00;

      vecs[0] = '{2'b10, 8'hA5, 8'h5A, 1'b1, 8'hA5};
      vecs[1] = '{2'b11, 8'h00, 8'h3C, 1'b1, 8'h3C};
      vecs[2] = '{2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00};
      vecs[3] = '{2'b01, 8'h81, 8'h81, 1'b0, 8'h00};
      vecs[4] = '{2'b10, 8'h01, 8'h80, 1'b1, 8'h01};
      vecs[5] = '{2'b11, 8'h7F, 8'hFE, 1'b1, 8'hFE};

      // Reset with random inputs
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         bus.rpi_sclk   = 1'($urandom);
         bus.rpi_sle    = 1'($urandom);
         bus.rpi_regsel = 2'($urandom);
         bus.ti_td      = 8'($urandom);
         bus.ti_tc      = 8'($urandom);
         @(negedge clk);
         check("rst_sdata", bus.rpi_sdata_out, 1'b0);
         check("rst_busy", bus.busy, 1'b0);
      end
      @(posedge clk); #1;
      bus.rpi_sclk = 1'b0; bus.rpi_sle = 1'b0; bus.rpi_regsel = 2'b10;
      bus.ti_td = 8'hFF;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      shift_check("idle_sclk", 8'hFF, 5, 0, 1'b0);

      // Table-driven reads
      foreach (vecs[k]) begin
         @(posedge clk); #1;
         bus.rpi_regsel = vecs[k].regsel;
         bus.ti_td      = vecs[k].td;
         bus.ti_tc      = vecs[k].tc;
         repeat (6) @(posedge clk);
         pulse_sle();
         shift_check($sformatf("vec%0d", k), vecs[k].exp, 8, 0, vecs[k].valid);
         check_idle($sformatf("vec%0d", k));
      end

      // Race: TD changes while the load strobe is being detected
      @(posedge clk); #1;
      bus.rpi_regsel = 2'b10; bus.ti_td = 8'h00;
      repeat (6) @(posedge clk);
      #1 bus.rpi_sle = 1'b1;
      repeat (SYNC) @(posedge clk);
      #1 bus.ti_td = 8'hFF;
      repeat (8) @(posedge clk);
      #1 bus.rpi_sle = 1'b0;
      repeat (10) @(posedge clk);
      shift_check("race", 8'hFF, 8, 0, 1'b1);
      check_idle("race");

      // Abort: re-strobe after 3 bits with new latch contents
      @(posedge clk); #1 bus.ti_td = 8'h81;
      pulse_sle();
      shift_check("abort_a", 8'h81, 3, 0, 1'b1);
      @(posedge clk); #1 bus.ti_td = 8'h7E;
      pulse_sle();
      shift_check("abort_b", 8'h7E, 8, 0, 1'b1);
      check_idle("abort");

      // Mid-transfer asynchronous reset
      @(posedge clk); #1 bus.ti_td = 8'hFF;
      pulse_sle();
      shift_check("mrst_a", 8'hFF, 4, 0, 1'b1);
      @(negedge clk);
      check("mrst_pre_busy", bus.busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_sdata", bus.rpi_sdata_out, 1'b0);
      check("mrst_busy", bus.busy, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      bus.rpi_regsel = 2'b11; bus.ti_tc = 8'h3C;
      repeat (6) @(posedge clk);
      pulse_sle();
      shift_check("mrst_b", 8'h3C, 8, 0, 1'b1);
      check_idle("mrst_b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
